// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter, LSB first, for the 50 MHz fabric.
//
// Double-buffered: a holding register lets software queue the next byte while
// the shift register is on the line. Frames can run back-to-back with no gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (11-bit frame). Without it the frame is
// 10 bits and no parity logic exists.
//
// Parameters:
//   UART_CLOCK  clock cycles per bit (default 434 = 50 MHz / 115.2 kbaud),
//               legal range 2..511
//
// Ports:
//   clock_50M  in   system clock, all logic on rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   write strobe, byte accepted when start=1 and ready=1
//   tx_data    in   byte to send, sampled only on acceptance
//   ready      out  holding register empty, a write will be accepted
//   busy       out  a frame (start..stop) is on the line
//   tx         out  serial line, registered, idles high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter logic [8:0] UART_CLOCK = 9'd434
) (
  input  logic       clock_50M,
  input  logic       n_rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] clock_count_q, clock_count_d;
  logic [2:0] bit_index_q, bit_index_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       tx_q, tx_d;

  logic accept;
  logic bit_last;

  assign ready = ~hold_valid_q;
  assign busy  = (state_q != StIdle);
  assign tx    = tx_q;

  assign accept   = start & ~hold_valid_q;
  assign bit_last = (clock_count_q == (UART_CLOCK - 9'd1));

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;

    if (state_q != StIdle) begin
      clock_count_d = bit_last ? 9'd0 : clock_count_q + 9'd1;
    end

    case (state_q)
      StIdle: begin
        clock_count_d = 9'd0;
        bit_index_d   = 3'd0;
        // Idle write bypasses the holding register straight into the shifter.
        if (accept) begin
          shift_d = tx_data;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_last) begin
          state_d     = StData;
          bit_index_d = 3'd0;
        end
      end

      StData: begin
        if (bit_last) begin
          if (bit_index_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_last) begin
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (bit_last) begin
          // Chain the next frame without an idle gap when a byte is waiting,
          // either queued earlier or written on this very cycle.
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            state_d      = StStart;
          end else if (accept) begin
            shift_d = tx_data;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Writes during a frame are queued, except on the final stop cycle where
    // the byte has already gone directly to the shifter above.
    if (accept && (state_q != StIdle) && !((state_q == StStop) && bit_last)) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end
  end

  // Line level is derived from the next state so tx changes only on bit
  // boundaries and comes straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[bit_index_d];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = ^shift_d;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock_50M or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      clock_count_q <= 9'd0;
      bit_index_q   <= 3'd0;
      shift_q       <= 8'h00;
      hold_q        <= 8'h00;
      hold_valid_q  <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      tx_q          <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter (8N1, LSB first) for the 50 MHz fabric; serialises bytes from the CPU/IO side onto the tx line at 115.2 kbaud.
- Double-buffered: one holding register plus one shift register, so software can queue the next byte while a frame is on the line.
- Frames can go back-to-back with no idle gap.
- Pairs with the codebase's UART receive path on the same link.

Parameters:
- UART_CLOCK, 9'd434, clock cycles per bit (50 MHz / 115.2 kHz). Legal range 2..511. Counter width is 9 bits.

Ports:
- clock_50M  input  1  system clock, 50 MHz, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  write strobe; byte accepted on a rising edge where start=1 and ready=1
- tx_data  input  8  byte to send; sampled only on acceptance
- ready  output  1  1 = holding register empty, a write will be accepted
- busy  output  1  1 = a frame (start..stop) is currently on the line
- tx  output  1  serial line, registered, idles high

Behaviour:
- Reset (async, n_rst=0):
  - tx=1, ready=1, busy=0.
  - Holding register invalid, state IDLE, bit counter 0, bit index 0.
  - Applies immediately mid-frame; the partial frame is abandoned and both buffers are discarded.
- States: IDLE, START, DATA, (PARITY, macro only), STOP. Each non-IDLE state lasts exactly UART_CLOCK cycles, timed by clock_count 0..UART_CLOCK-1.
- Acceptance at edge k:
  - If IDLE and holding empty: tx_data loads the shift register directly, state becomes START, and tx=0 and busy=1 from edge k. ready stays 1.
  - If a frame is in progress and holding empty: tx_data loads the holding register and ready=0 from edge k.
  - start while ready=0 is ignored: no data change, no error flag.
- DATA: 8 bit periods, bit 0 first, tx = shift[index]. Index 0..7, then advance to STOP (or PARITY).
- STOP: tx=1 for UART_CLOCK cycles. On its last cycle:
  - If holding valid: move holding to shift register, enter START (tx=0 on the next edge), clear holding (ready=1 on the next edge). busy stays 1. No idle gap.
  - Else if start=1 on that same cycle (holding empty, so ready=1): the byte goes directly to the shift register and enters START. Back-to-back, no gap.
  - Else: enter IDLE, busy=0, tx stays 1.
- Frame length: 10 × UART_CLOCK cycles (11 × with parity).
- tx never glitches. It changes only at bit boundaries or on reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between bit 7 and STOP, lasting UART_CLOCK cycles. tx = XOR of the 8 data bits (even parity). Frame is 11 bits.
- Undefined: no PARITY state exists; frame is 10 bits; no parity logic is synthesised.

Test Plan:
- Reset, idle 1000 cycles -> tx=1, ready=1, busy=0 throughout.
- Write 0x55 at edge k -> tx from edge k: 0,1,0,1,0,1,0,1,0 then stop 1. Each level held exactly 434 cycles. busy falls at k+4340. ready stays 1 the whole frame.
- Write 0xA3, then 0x0F at k+100 -> ready=0 from k+100 until k+4340. Second start bit begins at k+4340 with no gap. Second frame decodes 0x0F. busy stays 1 for 8680 cycles.
- While ready=0, strobe start with 0xFF -> ignored; the line carries only 0xA3 then 0x0F.
- Drop n_rst at k+2000 mid-frame -> tx=1, ready=1, busy=0 immediately. After release, a new 0x3C write transmits cleanly.
- With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 after bit 7, frame of 4774 cycles. Write 0x03 -> parity bit 0.
